stream_mux_rr: RTL and testbench

STREAM_MUX_RR -- requirements
Module: stream_mux_rr

---
 rtl/stream_mux_rr_if.sv | 31 +++
 rtl/stream_mux_rr.sv | 87 ++++++++
 tb/tb_stream_mux_rr.sv | 262 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/stream_mux_rr_if.sv
// stream_mux_rr_if: handshake bundle between the N input streams and the single output stream.
// Ports/signals:
//   in_valid[N], in_data[N*W], sel[SW]  - per-channel requests, data and external select
//   in_ready[N]                         - per-channel accept, one-hot or zero
//   out_valid, out_data[W], out_chan[SW] - registered output word and its source channel
//   out_ready                           - downstream accept
//   xfer_cnt[16]                        - completed output transfer count
// Modports: master = stream source/sink side, slave = the mux.
interface stream_mux_rr_if #(
    parameter int N  = 8,
    parameter int W  = 8,
    parameter int SW = 3
);
    logic [N-1:0]   in_valid;
    logic [N-1:0]   in_ready;
    logic [N*W-1:0] in_data;
    logic [SW-1:0]  sel;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   out_data;
    logic [SW-1:0]  out_chan;
    logic [15:0]    xfer_cnt;
    modport master (
        output in_valid, in_data, sel, out_ready,
        input  in_ready, out_valid, out_data, out_chan, xfer_cnt
    );
    modport slave (
        input  in_valid, in_data, sel, out_ready,
        output in_ready, out_valid, out_data, out_chan, xfer_cnt
    );
endinterface

// File: rtl/stream_mux_rr.sv
// stream_mux_rr: N-to-1 stream multiplexer with registered output, external select or round-robin.
// Ports:
//   clk     - clock, all state on rising edge
//   reset_n - synchronous active-low reset
//   bus     - stream_mux_rr_if.slave: in_valid/in_ready/in_data/sel in, out_valid/out_ready/out_data/out_chan out, xfer_cnt
// Parameters: N channels, W data bits, SW channel-index bits, MODE (0 = external sel, 1 = round-robin).
// Optional feature: define STREAM_MUX_RR_CNT_EN to enable the 16-bit transfer counter (else xfer_cnt = 0).
module stream_mux_rr #(
    parameter int N    = 8,
    parameter int W    = 8,
    parameter int SW   = 3,
    parameter int MODE = 0
) (
    input logic            clk,
    input logic            reset_n,
    stream_mux_rr_if.slave bus
);
    localparam int SW1 = SW + 1;
    localparam logic [SW:0] NL = SW1'(N);
    typedef enum logic {EMPTY, FULL} state_t;
    state_t        state, state_nx;
    logic [SW-1:0] ptr, start, off, rr_c, c, chan_q;
    logic [SW:0]   sum;
    logic [N-1:0]  rot, onehot;
    logic [W-1:0]  data_q;
    logic          rr_hit, in_range, load, grant;

    // Search begins one past the last granted channel, wrapping at N.
    assign start = ({1'b0, ptr} == NL - 1'b1) ? '0 : ptr + 1'b1;
    assign rot   = N'({bus.in_valid, bus.in_valid} >> start);

    // Lowest set bit of the rotated request vector is the nearest channel after ptr.
    always_comb begin
        off    = '0;
        rr_hit = 1'b0;
        for (int i = N - 1; i >= 0; i--)
            if (rot[i]) begin
                off    = SW'(i);
                rr_hit = 1'b1;
            end
    end

    assign sum      = {1'b0, start} + {1'b0, off};
    assign rr_c     = (sum >= NL) ? SW'(sum - NL) : sum[SW-1:0];
    assign c        = (MODE == 0) ? bus.sel : rr_c;
    assign in_range = {1'b0, c} < NL;
    assign onehot   = N'(1) << c;
    assign load     = (state == EMPTY) | bus.out_ready;
    assign grant    = reset_n & load & in_range & (|(bus.in_valid & onehot));

    assign bus.in_ready  = (reset_n & load & in_range & ((MODE == 0) | rr_hit)) ? onehot : '0;
    assign bus.out_valid = state == FULL;
    assign bus.out_data  = data_q;
    assign bus.out_chan  = chan_q;

    always_comb begin
        state_nx = state;
        if (load) state_nx = grant ? FULL : EMPTY;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state  <= EMPTY;
            data_q <= '0;
            chan_q <= '0;
            ptr    <= SW'(N - 1);
        end else begin
            state <= state_nx;
            if (grant) begin
                data_q <= W'(bus.in_data >> (c * W));
                chan_q <= c;
            end
            if (grant && MODE == 1) ptr <= c;
        end
    end

`ifdef STREAM_MUX_RR_CNT_EN
    logic [15:0] cnt_q;
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else if (state == FULL && bus.out_ready) cnt_q <= cnt_q + 1'b1;
    end
    assign bus.xfer_cnt = cnt_q;
`else
    assign bus.xfer_cnt = '0;
`endif
endmodule

// File: tb/tb_stream_mux_rr.sv
// tb_stream_mux_rr: checks an external-select mux (unit 0, SW=4) and a round-robin mux (unit 1) against a stream-level model.
module tb_stream_mux_rr;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [7:0] iv[2];
    logic [63:0] idt[2];
    logic [3:0] isel;
    logic       ordy[2];
    logic [7:0] o_rdy[2], o_d[2];
    logic [3:0] o_c[2];
    logic       o_v[2];
    logic [15:0] o_n[2];
    // model state: word held, its data/channel, last granted channel, transfer count
    logic       m_v[2] = '{1'b0, 1'b0};
    logic [7:0] m_d[2];
    int         m_c[2];
    int         m_p[2] = '{7, 7};
    logic [15:0] m_n[2] = '{16'h0, 16'h0};
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    stream_mux_rr_if #(.N(8), .W(8), .SW(4)) ia ();
    stream_mux_rr_if #(.N(8), .W(8), .SW(3)) ib ();

    stream_mux_rr #(.N(8), .W(8), .SW(4), .MODE(0)) dut_a (.clk(clk), .reset_n(rst_n), .bus(ia));
    stream_mux_rr #(.N(8), .W(8), .SW(3), .MODE(1)) dut_b (.clk(clk), .reset_n(rst_n), .bus(ib));

    assign ia.in_valid  = iv[0];
    assign ia.in_data   = idt[0];
    assign ia.sel       = isel;
    assign ia.out_ready = ordy[0];
    assign ib.in_valid  = iv[1];
    assign ib.in_data   = idt[1];
    assign ib.sel       = '0;
    assign ib.out_ready = ordy[1];
    assign o_rdy[0] = ia.in_ready;
    assign o_rdy[1] = ib.in_ready;
    assign o_v[0]   = ia.out_valid;
    assign o_v[1]   = ib.out_valid;
    assign o_d[0]   = ia.out_data;
    assign o_d[1]   = ib.out_data;
    assign o_c[0]   = ia.out_chan;
    assign o_c[1]   = {1'b0, ib.out_chan};
    assign o_n[0]   = ia.xfer_cnt;
    assign o_n[1]   = ib.xfer_cnt;

    initial forever #5 clk = ~clk;

    task automatic chk(input string n, input int u, input logic [63:0] a, input logic [63:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s unit%0d got %0h expected %0h at %0t", n, u, a, e, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Candidate channel: the select value, or the first requester after the last grant.
    function automatic void pick(input bit rr, input int s, input logic [7:0] v, input int p,
                                 output int ch, output bit ok);
        ch = s;
        ok = s < 8;
        if (rr) begin
            ch = 0;
            ok = 1'b0;
            for (int k = 1; k <= 8; k++)
                if (!ok && v[(p + k) % 8]) begin
                    ch = (p + k) % 8;
                    ok = 1'b1;
                end
        end
    endfunction

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int u = 0; u < 2; u++) begin
            int ch;
            bit ok, ld, g;
            pick(u == 1, int'(isel), iv[u], m_p[u], ch, ok);
            ld = !m_v[u] || ordy[u];
            g  = ok && iv[u][ch];
            if (!rst_n) begin
                m_v[u] <= 1'b0;
                m_d[u] <= 8'h00;
                m_c[u] <= 0;
                m_p[u] <= 7;
                m_n[u] <= 16'h0;
            end else begin
`ifdef STREAM_MUX_RR_CNT_EN
                if (m_v[u] && ordy[u]) m_n[u] <= m_n[u] + 16'h1;
`endif
                if (ld) begin
                    m_v[u] <= g;
                    if (g) begin
                        m_d[u] <= idt[u][ch*8 +: 8];
                        m_c[u] <= ch;
                        if (u == 1) m_p[u] <= ch;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (cyc > 0)
            for (int u = 0; u < 2; u++) begin
                int ch;
                bit ok, ld;
                logic [7:0] er;
                pick(u == 1, int'(isel), iv[u], m_p[u], ch, ok);
                ld = !m_v[u] || ordy[u];
                er = (rst_n && ld && ok) ? 8'(1 << ch) : 8'h00;
                chk("model_in_ready", u, o_rdy[u], er);
                chk("model_out_valid", u, o_v[u], m_v[u]);
                if (m_v[u]) begin
                    chk("model_out_data", u, o_d[u], m_d[u]);
                    chk("model_out_chan", u, o_c[u], m_c[u]);
                end
                chk("model_xfer_cnt", u, o_n[u], m_n[u]);
            end
    end

    initial begin
        rst_n  = 1'b0;
        iv[0]  = 8'hFF;
        iv[1]  = 8'hFF;
        idt[0] = 64'h0706A50403020100;
        idt[1] = 64'h1716151413121110;
        isel   = 4'd5;
        ordy[0] = 1'b1;
        ordy[1] = 1'b1;
        step();
        @(negedge clk);
        for (int u = 0; u < 2; u++) begin
            chk("rst_in_ready", u, o_rdy[u], 0);
            chk("rst_out_valid", u, o_v[u], 0);
            chk("rst_out_data", u, o_d[u], 0);
            chk("rst_out_chan", u, o_c[u], 0);
            chk("rst_xfer_cnt", u, o_n[u], 0);
        end
        step();
        rst_n = 1'b1;
        iv[0] = 8'h20;
        for (int k = 0; k < 11; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("sel5_in_ready", 0, o_rdy[0], 8'h20);
                chk("rr_first_ready", 1, o_rdy[1], 8'h01);
            end
            if (k == 1) begin
                chk("sel5_out_valid", 0, o_v[0], 1);
                chk("sel5_out_data", 0, o_d[0], 8'hA5);
                chk("sel5_out_chan", 0, o_c[0], 5);
            end
            if (k >= 1) begin
                chk("rr_seq_valid", 1, o_v[1], 1);
                chk("rr_seq_chan", 1, o_c[1], (k - 1) % 8);
            end
            step();
            if (k == 9) iv[1] = 8'h00;
        end
        rst_n = 1'b0;
        iv[1] = 8'hFF;
        @(negedge clk);
        chk("rst_low_ready", 0, o_rdy[0], 0);
        chk("rst_low_ready", 1, o_rdy[1], 0);
        step();
        @(negedge clk);
        chk("rst_drop_valid", 0, o_v[0], 0);
        chk("rst_drop_valid", 1, o_v[1], 0);
        step();
        rst_n = 1'b1;
        iv[1] = 8'h81;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            chk("wrap_in_ready", 1, o_rdy[1], (k % 2 == 0) ? 8'h01 : 8'h80);
            if (k >= 1) chk("wrap_out_chan", 1, o_c[1], (k % 2 == 1) ? 0 : 7);
            step();
        end
        isel = 4'd3;
        iv[0] = 8'h08;
        idt[0][31:24] = 8'h3C;
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_load_ready", 0, o_rdy[0], 8'h08);
        step();
        ordy[0] = 1'b0;
        idt[0][31:24] = 8'h5A;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("bp_hold_valid", 0, o_v[0], 1);
            chk("bp_hold_data", 0, o_d[0], 8'h3C);
            chk("bp_hold_ready", 0, o_rdy[0], 0);
            step();
        end
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("bp_release_data", 0, o_d[0], 8'h3C);
        chk("bp_release_ready", 0, o_rdy[0], 8'h08);
        step();
        @(negedge clk);
        chk("bp_new_data", 0, o_d[0], 8'h5A);
        chk("bp_new_chan", 0, o_c[0], 3);
        step();
        isel = 4'd9;
        iv[0] = 8'hFF;
        ordy[0] = 1'b0;
        @(negedge clk);
        chk("sel9_ready", 0, o_rdy[0], 0);
        chk("sel9_held", 0, o_v[0], 1);
        step();
        ordy[0] = 1'b1;
        @(negedge clk);
        chk("sel9_drain_ready", 0, o_rdy[0], 0);
        chk("sel9_drain_valid", 0, o_v[0], 1);
        step();
        @(negedge clk);
        chk("sel9_empty", 0, o_v[0], 0);
        step();
        iv[1] = 8'hFF;
        ordy[1] = 1'b1;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
`ifdef STREAM_MUX_RR_CNT_EN
        repeat (65536) step();
        @(negedge clk);
        chk("cnt_ffff", 1, o_n[1], 16'hFFFF);
        step();
        @(negedge clk);
        chk("cnt_wrap", 1, o_n[1], 16'h0000);
`else
        repeat (20) step();
        @(negedge clk);
        chk("cnt_stream_valid", 1, o_v[1], 1);
        chk("cnt_tied_zero", 1, o_n[1], 16'h0000);
`endif
        step();
        rst_n = 1'b0;
        step();
        @(negedge clk);
        chk("mid_rst_valid", 1, o_v[1], 0);
        chk("mid_rst_cnt", 1, o_n[1], 0);
        chk("mid_rst_ready", 1, o_rdy[1], 0);
        iv[0] = 8'h00;
        iv[1] = 8'h00;
        step();
        rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("post_rst_valid", 1, o_v[1], 0);
        chk("post_rst_cnt", 1, o_n[1], 0);
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
